// File: rtl/proc_pkg.sv
// proc_pkg -- shared definitions for the instruction fetch path.
//
// Holds the fetch FSM state type, the default address width and timeout,
// the bit positions of the op/funct fields inside the assembled 32-bit
// instruction, and the location of the length code inside byte 0.
// No ports (package).

package proc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } fetch_state_t;

    localparam int ADDR_W_DEF   = 16;
    localparam int TIMEOUT_DEF  = 15;

    // Instruction field positions within ir[31:0].
    localparam int OP_MSB       = 31;
    localparam int OP_W         = 6;
    localparam int FUNCT_MSB    = 18;
    localparam int FUNCT_W      = 3;

    // Length field: byte0[1:0] holds (length - 1), length is 1..4 bytes.
    localparam int LEN_CODE_MSB = 1;
    localparam int LEN_CODE_LSB = 0;
    localparam int LEN_CODE_W   = LEN_CODE_MSB - LEN_CODE_LSB + 1;
    localparam int LEN_W        = 3;

    // Bit offset of byte k inside ir: byte 0 lands in [31:24], byte 3 in [7:0].
    // 24 - 8k is simply the inverted byte index shifted left by 3.
    function automatic logic [4:0] byte_lsb(input logic [1:0] k);
        return {~k, 3'b000};
    endfunction

endpackage

// File: rtl/fetch_len_dec.sv
// fetch_len_dec -- combinational decode of the instruction length.
//
// Ports:
//   code  in   LEN_CODE_W  length field taken from byte 0 of the instruction
//   len   out  LEN_W       instruction length in bytes, 1..4

module fetch_len_dec
    import proc_pkg::*;
(
    input  logic [LEN_CODE_W-1:0] code,
    output logic [LEN_W-1:0]      len
);

    assign len = {1'b0, code} + 3'd1;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit -- fetches one variable-length (1..4 byte) instruction
// byte by byte from a byte-wide memory port and assembles it big-endian.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   reset      in   1       asynchronous active-high reset
//   start      in   1       fetch one instruction at pc (ignored while busy)
//   flush      in   1       abort, return to IDLE (beats start)
//   pc         in   ADDR_W  instruction byte address, latched on start
//   mem_rd     out  1       byte read request
//   mem_addr   out  ADDR_W  byte read address
//   mem_rdata  in   8       read data
//   mem_ready  in   1       read completes this cycle
//   ir         out  32      assembled instruction, byte0 in [31:24]
//   op         out  6       ir[31:26]
//   funct      out  3       ir[18:16]
//   len        out  3       instruction length in bytes
//   valid      out  1       ir/op/funct/len complete
//   busy       out  1       fetch in progress (REQ)
//   err        out  1       fetch timed out
//   state      out  2       current FSM state, for observation
//
// Memory handshake: a byte transfers in every cycle where mem_rd=1 and
// mem_ready=1; mem_rd stays high and mem_addr stays put until that happens.

module instr_fetch_unit
    import proc_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       ir,
    output logic [OP_W-1:0]   op,
    output logic [FUNCT_W-1:0] funct,
    output logic [LEN_W-1:0]  len,
    output logic              valid,
    output logic              busy,
    output logic              err,
    output fetch_state_t      state
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [1:0]        count;
    logic [WAIT_W-1:0] wait_cnt;
    logic [LEN_W-1:0]  dec_len;
    logic [LEN_W-1:0]  eff_len;
    logic              last_byte;

    fetch_len_dec u_len_dec (
        .code (mem_rdata[LEN_CODE_MSB:LEN_CODE_LSB]),
        .len  (dec_len)
    );

    // On byte 0 the stored len is not yet known, so use the live decode.
    assign eff_len   = (count == 2'd0) ? dec_len : len;
    assign last_byte = (({1'b0, count} + 3'd1) == eff_len);

    // All of these derive only from registered state.
    assign op    = ir[OP_MSB -: OP_W];
    assign funct = ir[FUNCT_MSB -: FUNCT_W];
    assign busy  = (state == REQ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 2'd0;
            wait_cnt <= '0;
            ir       <= 32'd0;
            len      <= 3'd1;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else if (flush) begin
            // ir and len keep whatever they held; start is dropped.
            state    <= IDLE;
            count    <= 2'd0;
            wait_cnt <= '0;
            mem_rd   <= 1'b0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= REQ;
                        count    <= 2'd0;
                        wait_cnt <= '0;
                        ir       <= 32'd0;
                        len      <= 3'd1;
                        mem_addr <= pc;
                        mem_rd   <= 1'b1;
                        valid    <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        ir[byte_lsb(count) +: 8] <= mem_rdata;
                        if (count == 2'd0) begin
                            len <= dec_len;
                        end
                        if (last_byte) begin
                            state  <= DONE;
                            mem_rd <= 1'b0;
                            valid  <= 1'b1;
                        end else begin
                            count    <= count + 2'd1;
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        state  <= ERR;
                        mem_rd <= 1'b0;
                        valid  <= 1'b0;
                        err    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_rd <= 1'b0;
                end
            endcase
        end
    end

endmodule
